// File: rtl/writeback_buffer_if.sv
// Bundle of the victim hand-off, hazard-check and memory write-port signals
// shared between the cache controller, the write-back buffer and main memory.
interface writeback_buffer_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32
);
    logic                       victim_valid;
    logic                       victim_dirty;
    logic [ADDRESS_WIDTH-1:0]   victim_addr;
    logic [BLOCK_SIZE*8-1:0]    victim_data;
    logic                       victim_ready;
    logic                       victim_done;
    logic [ADDRESS_WIDTH-1:0]   check_addr;
    logic                       check_hit;
    logic                       mem_req;
    logic [ADDRESS_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic                       mem_last;
    logic                       mem_ready;
    logic                       empty;
    logic                       full;

    // Controller and memory side.
    modport master (
        output victim_valid, victim_dirty, victim_addr, victim_data,
        output check_addr, mem_ready,
        input  victim_ready, victim_done, check_hit,
        input  mem_req, mem_addr, mem_wdata, mem_last, empty, full
    );

    // Write-back buffer side.
    modport slave (
        input  victim_valid, victim_dirty, victim_addr, victim_data,
        input  check_addr, mem_ready,
        output victim_ready, victim_done, check_hit,
        output mem_req, mem_addr, mem_wdata, mem_last, empty, full
    );
endinterface

// File: rtl/writeback_buffer.sv
// Dirty-victim write-back buffer: queues dirty cache lines in a small FIFO and
// drains them word by word to memory, flagging refills that hit a pending line.
module writeback_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int DEPTH         = 2
) (
    input  logic               clk,
    input  logic               reset,
    writeback_buffer_if.slave  bus
);
    localparam int WORDS      = BLOCK_SIZE * 8 / DATA_WIDTH;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int BEAT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LINE_W     = BLOCK_SIZE * 8;
    localparam int WORD_BYTES = DATA_WIDTH / 8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [BEAT_W-1:0]        LAST_BEAT  = BEAT_W'(WORDS - 1);
    localparam logic [PTR_W:0]           FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] BLOCK_MASK = ~ADDRESS_WIDTH'(BLOCK_SIZE - 1);

    logic [0:0]               r_state;
    logic [BEAT_W-1:0]        r_beat;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W:0]           r_count;
    logic [DEPTH-1:0]         r_vld;
    logic                     r_done;
    logic [ADDRESS_WIDTH-1:0] r_addr_mem [DEPTH];
    logic [LINE_W-1:0]        r_line_mem [DEPTH];

    logic                     w_full;
    logic                     w_empty;
    logic                     w_victim_ready;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_sending;
    logic                     w_pop;
    logic                     w_hit;
    logic [LINE_W-1:0]        w_line;
    logic [DATA_WIDTH-1:0]    w_words [WORDS];

    assign w_full         = (r_count == FULL_COUNT);
    assign w_empty        = (r_count == '0);
    // Clean victims never need storage, so they are accepted even when full.
    assign w_victim_ready = !w_full || !bus.victim_dirty;
    assign w_accept       = bus.victim_valid && w_victim_ready;
    assign w_push         = w_accept && bus.victim_dirty;
    assign w_sending      = (r_state == S_SEND);
    assign w_pop          = w_sending && bus.mem_ready && (r_beat == LAST_BEAT);

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (((r_addr_mem[i] ^ bus.check_addr) & BLOCK_MASK) == '0)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign w_line = r_line_mem[r_rd_ptr];

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            w_words[i] = w_line[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.victim_ready = w_victim_ready;
    assign bus.victim_done  = r_done;
    assign bus.check_hit    = w_hit;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.mem_req      = w_sending;
    // Beat fields are forced to zero outside SEND so they read zero from reset.
    assign bus.mem_addr     = w_sending
                              ? r_addr_mem[r_rd_ptr] + (ADDRESS_WIDTH'(r_beat) * ADDRESS_WIDTH'(WORD_BYTES))
                              : '0;
    assign bus.mem_wdata    = w_sending ? w_words[r_beat] : '0;
    assign bus.mem_last     = w_sending && (r_beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_accept;

            if (w_push) begin
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_vld[r_wr_ptr] <= 1'b1;
            end
            // A push never targets the slot being popped: that needs count == DEPTH.
            if (w_pop) begin
                r_rd_ptr        <= r_rd_ptr + 1'b1;
                r_vld[r_rd_ptr] <= 1'b0;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_SEND;
                        r_beat  <= '0;
                    end
                end
                S_SEND: begin
                    if (bus.mem_ready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state <= S_IDLE;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Line storage carries no reset; validity lives in r_vld and r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= bus.victim_addr & BLOCK_MASK;
            r_line_mem[r_wr_ptr] <= bus.victim_data;
        end
    end
endmodule

// File: doc/writeback_buffer.md
# writeback_buffer

Dirty-victim write-back buffer that sits directly downstream of the cache controller's MISS state. The controller hands it the line chosen by the eviction policy. Clean lines are acknowledged and discarded. Dirty lines are queued in a small FIFO and drained word-by-word to main memory over a valid/ready write port. An address-check port tells the controller when a refill address still has a pending write-back, so the controller does not read stale memory.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, memory write-port word width in bits
- BLOCK_SIZE, 32, cache line size in bytes; BLOCK_SIZE*8 must be a multiple of DATA_WIDTH
- DEPTH, 2, buffered dirty lines; power of two, ≥ 2
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- victim_valid  in  1  controller presents a victim line
- victim_dirty  in  1  victim line is dirty
- victim_addr  in  ADDRESS_WIDTH  victim byte address; low $clog2(BLOCK_SIZE) bits ignored
- victim_data  in  BLOCK_SIZE*8  full line; word 0 = bits [DATA_WIDTH-1:0]
- victim_ready  out  1  combinational: !full || !victim_dirty
- victim_done  out  1  registered one-cycle pulse, cycle after acceptance
- check_addr  in  ADDRESS_WIDTH  refill address to test
- check_hit  out  1  combinational: block address of check_addr matches any valid entry
- mem_req  out  1  write beat valid
- mem_addr  out  ADDRESS_WIDTH  beat byte address
- mem_wdata  out  DATA_WIDTH  beat data
- mem_last  out  1  final beat of the line
- mem_ready  in  1  memory accepts beat
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- WORDS = BLOCK_SIZE*8/DATA_WIDTH. OFFSET = $clog2(BLOCK_SIZE). Entry address is stored block-aligned, with low OFFSET bits zero.
- Accept occurs when victim_valid && victim_ready.
  - Dirty: write {addr, data} at wr_ptr, then increment wr_ptr and count.
  - Clean: no storage change.
  - Both cases: victim_done = 1 next cycle.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- Drain FSM has two states, IDLE and SEND.
  - IDLE: if count > 0, go to SEND with beat = 0.
  - SEND: mem_req = 1. mem_addr = entry.addr + beat*(DATA_WIDTH/8). mem_wdata = word[beat]. mem_last = (beat == WORDS-1).
  - On mem_ready in SEND:
    - If beat < WORDS-1, increment beat.
    - Otherwise, pop (increment rd_ptr, decrement count) and go to IDLE.
- While mem_req && !mem_ready, mem_addr, mem_wdata and mem_last hold stable.
- check_hit covers all valid entries, including the one being drained. It clears the cycle after its last beat is accepted.
- A push in cycle T is not visible to check_hit until T+1.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- victim_ready is based on count at the start of the cycle. When full, no dirty push is accepted even if a pop completes in that cycle.
- Reset values:
  - count = 0, rd_ptr = wr_ptr = 0, beat = 0, state = IDLE.
  - mem_req = 0, mem_last = 0, victim_done = 0.
  - empty = 1, full = 0.
  - mem_addr and mem_wdata = 0.
- Reset asserted mid-drain discards all entries. No further beats are issued, and the memory side must tolerate the truncated line.

## Timing
- Accept at cycle T: the entry is stored at T+1, FSM enters SEND at T+2, and the first mem_req is at T+2.
- With mem_ready held high: beats at T+2 … T+1+WORDS; pop on the last beat; empty at T+2+WORDS.
- Every line has exactly one IDLE cycle before the next line's first beat.
- victim_done always arrives exactly 1 cycle after acceptance. This holds for clean and dirty victims alike.
- check_hit, victim_ready, empty and full are purely combinational from registered state plus inputs. There is no added latency.

## Test plan
- **Reset:** hold reset 2 cycles with victim_valid = 1 → no accept; after release, empty = 1, full = 0, mem_req = 0, victim_done = 0.
- **Clean victim:** victim_valid = 1, victim_dirty = 0, addr 0x1000 → victim_ready = 1, victim_done pulse next cycle, empty stays 1, mem_req never asserts.
- **Single dirty line:** victim addr 0x2004, data words 0..7 = 0xA0..0xA7, mem_ready = 1 → 8 beats at 0x2000, 0x2004 … 0x201C with data 0xA0 … 0xA7; mem_last on beat 7; first beat 2 cycles after accept; empty at accept+10.
- **Back-pressure:** same line with mem_ready low for 3 cycles on beat 2 → mem_addr 0x2008 / 0xA2 held stable; beat count remains 8, with no duplicates or skips.
- **Full:** push dirty lines 0x3000 and 0x4000 with mem_ready = 0 → full = 1. A third dirty victim sees victim_ready = 0 while a clean victim is accepted. check_addr 0x4010 → check_hit = 1; check_addr 0x5000 → 0.
- **Hazard clear:** drain 0x3000 → check_hit for 0x3000 drops the cycle after its mem_last beat is accepted; 0x4000 drains next after one IDLE cycle.
